// File: rtl/ccrf_job_request_assembler_if.sv
// AXI-stream style handshake bundle; W sets the data width.
// The master drives valid/data/last, the slave returns ready.
interface ccrf_job_request_assembler_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/ccrf_job_request_assembler.sv
// Collects one host word packet per job into a descriptor, checks framing and image count,
// and holds a good descriptor until CcrfTopLevel takes it.
module ccrf_job_request_assembler #(
  parameter int IN_W       = 32,
  parameter int DESC_W     = 496,
  parameter int BEATS      = 16,
  parameter int MAX_IMAGES = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  ccrf_job_request_assembler_if.slave   host_words_V,
  ccrf_job_request_assembler_if.master  incoming_job_requests_V,
  output logic [CNT_W-1:0]              jobs_accepted,
  output logic [CNT_W-1:0]              err_short,
  output logic [CNT_W-1:0]              err_long,
  output logic [CNT_W-1:0]              err_count
);

  localparam int BW     = $clog2(BEATS);
  localparam int TAIL_W = DESC_W - IN_W*(BEATS-1);

  typedef enum logic [1:0] {COLLECT = 2'd0, HOLD = 2'd1, DISCARD = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [DESC_W-1:0] desc_q;
  logic              rdy_q;
  logic              acc, job_hs, last_beat, cnt_ok;
  logic              inc_short, inc_long, inc_cnt, inc_job;
  logic [7:0]        cnt_fld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // rdy_q keeps tready low through reset and raises it on the first edge after release
  assign host_words_V.tready           = rdy_q && (state_q != HOLD);
  assign incoming_job_requests_V.tvalid = (state_q == HOLD);
  assign incoming_job_requests_V.tdata  = desc_q;
  assign incoming_job_requests_V.tlast  = 1'b1;

  assign acc       = host_words_V.tvalid && host_words_V.tready;
  assign job_hs    = incoming_job_requests_V.tvalid && incoming_job_requests_V.tready;
  assign last_beat = (beat_q == BW'(BEATS-1));
  assign cnt_fld   = host_words_V.tdata[15:8];
  assign cnt_ok    = (cnt_fld != 8'd0) && (cnt_fld <= 8'(MAX_IMAGES));

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    inc_short = 1'b0;
    inc_long  = 1'b0;
    inc_cnt   = 1'b0;
    inc_job   = 1'b0;
    case (state_q)
      COLLECT: if (acc) begin
        if (host_words_V.tlast && !last_beat) begin
          inc_short = 1'b1;
          beat_d    = '0;
        end else if (last_beat) begin
          if (!host_words_V.tlast) begin
            inc_long = 1'b1;
            state_d  = DISCARD;
          end else if (cnt_ok) begin
            state_d = HOLD;
          end else begin
            inc_cnt = 1'b1;
            beat_d  = '0;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      HOLD: if (job_hs) begin
        inc_job = 1'b1;
        beat_d  = '0;
        state_d = COLLECT;
      end
      DISCARD: if (acc && host_words_V.tlast) begin
        beat_d  = '0;
        state_d = COLLECT;
      end
      default: begin
        beat_d  = '0;
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= COLLECT;
      beat_q        <= '0;
      rdy_q         <= 1'b0;
      jobs_accepted <= '0;
      err_short     <= '0;
      err_long      <= '0;
      err_count     <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rdy_q   <= 1'b1;
      if (inc_job)   jobs_accepted <= jobs_accepted + 1'b1;
      if (inc_short) err_short     <= sat_inc(err_short);
      if (inc_long)  err_long      <= sat_inc(err_long);
      if (inc_cnt)   err_count     <= sat_inc(err_count);
    end
  end

  // Never cleared between jobs: a full packet rewrites every bit, and the last beat only fills the tail
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      desc_q <= '0;
    end else if (state_q == COLLECT && acc) begin
      if (last_beat) desc_q[DESC_W-1 -: TAIL_W] <= host_words_V.tdata[TAIL_W-1:0];
      else           desc_q[int'(beat_q)*IN_W +: IN_W] <= host_words_V.tdata;
    end
  end

endmodule

// File: tb/tb_ccrf_job_request_assembler.sv
// Bench for ccrf_job_request_assembler: directed scenarios plus randomized packets against a packet-level model.
module tb_ccrf_job_request_assembler;
  localparam int IN_W = 32, DESC_W = 496, BEATS = 16, MAX_IMAGES = 8, CNT_W = 16;

  typedef logic [DESC_W-1:0] desc_t;
  typedef logic [31:0] wq_t[$];

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  ccrf_job_request_assembler_if #(.W(IN_W))   host ();
  ccrf_job_request_assembler_if #(.W(DESC_W)) job ();
  logic [CNT_W-1:0] jobs_accepted, err_short, err_long, err_count;

  ccrf_job_request_assembler #(
    .IN_W(IN_W), .DESC_W(DESC_W), .BEATS(BEATS), .MAX_IMAGES(MAX_IMAGES), .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .host_words_V(host), .incoming_job_requests_V(job),
    .jobs_accepted(jobs_accepted), .err_short(err_short),
    .err_long(err_long), .err_count(err_count)
  );

  int errors = 0, checks = 0;
  desc_t exp_q[$];
  int m_jobs = 0, m_short = 0, m_long = 0, m_count = 0;
  bit rand_rdy = 0;
  bit held = 0;
  desc_t held_d;

  // Job-side monitor: every handshake must match the next expected descriptor,
  // and a stalled descriptor must stay valid and unchanged.
  always @(posedge aclk) begin
    if (!aresetn) begin
      held = 0;
    end else begin
      if (held) begin
        checks++;
        if (job.tvalid !== 1'b1 || job.tdata !== held_d) begin
          errors++;
          $display("FAIL hold_stable tvalid=%b (want 1) data_changed=%b", job.tvalid, job.tdata !== held_d);
        end
      end
      if (job.tvalid === 1'b1 && job.tready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_job got=%h", job.tdata);
        end else begin
          desc_t e;
          e = exp_q.pop_front();
          if (job.tdata !== e) begin
            errors++;
            $display("FAIL job_desc got=%h want=%h", job.tdata, e);
          end
        end
      end
      held = (job.tvalid === 1'b1) && (job.tready !== 1'b1);
      held_d = job.tdata;
    end
  end

  function automatic desc_t build(input wq_t w);
    desc_t d = '0;
    for (int i = 0; i < BEATS-1; i++) d[32*i +: 32] = w[i];
    d[DESC_W-1 -: 16] = w[BEATS-1][15:0];
    return d;
  endfunction

  function automatic wq_t make_pkt(input int len, input logic [7:0] cnt);
    wq_t w;
    for (int i = 0; i < len; i++) w.push_back($urandom);
    if (len >= BEATS) w[BEATS-1][15:8] = cnt;
    return w;
  endfunction

  task automatic send_word(input logic [31:0] d, input bit last, input int gap);
    int n;
    host.tvalid = 1'b0;
    repeat (gap) begin @(posedge aclk); #1; end
    host.tvalid = 1'b1;
    host.tdata  = d;
    host.tlast  = last;
    n = 0;
    while (host.tready !== 1'b1 && n < 300) begin @(posedge aclk); #1; n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL host_ready_timeout tready=%b want 1", host.tready);
    end
    @(posedge aclk); #1;
    host.tvalid = 1'b0;
    host.tlast  = 1'b0;
  endtask

  // Packet-level model: framing decides the error class, the count field decides acceptance
  task automatic send_pkt(input wq_t w, input int max_gap);
    int len = w.size();
    if (len < BEATS) m_short++;
    else if (len > BEATS) m_long++;
    else if (w[BEATS-1][15:8] >= 1 && w[BEATS-1][15:8] <= MAX_IMAGES) begin
      exp_q.push_back(build(w));
      m_jobs++;
    end else m_count++;
    for (int i = 0; i < len; i++)
      send_word(w[i], i == len-1, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge aclk); #1; n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    checks += 4;
    if (jobs_accepted !== CNT_W'(m_jobs)) begin errors++; $display("FAIL %s jobs_accepted got=%0d want=%0d", tag, jobs_accepted, m_jobs); end
    if (err_short !== CNT_W'(m_short)) begin errors++; $display("FAIL %s err_short got=%0d want=%0d", tag, err_short, m_short); end
    if (err_long !== CNT_W'(m_long)) begin errors++; $display("FAIL %s err_long got=%0d want=%0d", tag, err_long, m_long); end
    if (err_count !== CNT_W'(m_count)) begin errors++; $display("FAIL %s err_count got=%0d want=%0d", tag, err_count, m_count); end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks += 3;
    if (host.tready !== 1'b0) begin errors++; $display("FAIL reset_host_tready got=%b want=0", host.tready); end
    if (job.tvalid !== 1'b0) begin errors++; $display("FAIL reset_job_tvalid got=%b want=0", job.tvalid); end
    if (job.tdata !== '0) begin errors++; $display("FAIL reset_desc got=%h want=0", job.tdata); end
    check_counters("reset");
    aresetn = 1'b1;
    #1;
    checks++;
    if (host.tready !== 1'b0) begin errors++; $display("FAIL release_tready_early got=%b want=0", host.tready); end
    @(posedge aclk); #1;
    checks++;
    if (host.tready !== 1'b1) begin errors++; $display("FAIL release_tready got=%b want=1", host.tready); end
  endtask

  function automatic wq_t case1_pkt();
    wq_t w;
    for (int i = 0; i < BEATS; i++) w.push_back(32'd0);
    w[0] = 32'd99;
    w[BEATS-1] = 32'h0000_0100;
    return w;
  endfunction

  task automatic test_good();
    desc_t want = '0;
    want[7:0] = 8'd99;
    want[495:488] = 8'd1;
    job.tready = 1'b1;
    send_pkt(case1_pkt(), 0);
    checks += 2;
    if (job.tvalid !== 1'b1) begin errors++; $display("FAIL good_latency tvalid=%b want=1", job.tvalid); end
    if (job.tdata !== want) begin errors++; $display("FAIL good_desc got=%h want=%h", job.tdata, want); end
    drain();
    check_counters("good");
  endtask

  task automatic test_backpressure();
    desc_t want;
    wq_t w = case1_pkt();
    want = build(w);
    job.tready = 1'b0;
    send_pkt(w, 0);
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (job.tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid cyc%0d got=%b want=1", i, job.tvalid); end
      if (host.tready !== 1'b0) begin errors++; $display("FAIL bp_host_tready cyc%0d got=%b want=0", i, host.tready); end
      if (job.tdata !== want) begin errors++; $display("FAIL bp_tdata cyc%0d got=%h want=%h", i, job.tdata, want); end
      @(posedge aclk); #1;
    end
    job.tready = 1'b1;
    @(posedge aclk); #1;
    checks += 2;
    if (job.tvalid !== 1'b0) begin errors++; $display("FAIL bp_release_tvalid got=%b want=0", job.tvalid); end
    if (host.tready !== 1'b1) begin errors++; $display("FAIL bp_release_host_tready got=%b want=1", host.tready); end
    drain();
    check_counters("backpressure");
  endtask

  task automatic test_short();
    send_pkt(make_pkt(8, 8'd0), 0);
    send_pkt(make_pkt(BEATS, 8'd3), 0);
    drain();
    check_counters("short");
  endtask

  task automatic test_long();
    send_pkt(make_pkt(21, 8'd2), 0);
    send_pkt(make_pkt(BEATS, 8'd5), 0);
    drain();
    check_counters("long");
  endtask

  task automatic test_count();
    send_pkt(make_pkt(BEATS, 8'd0), 0);
    send_pkt(make_pkt(BEATS, 8'd9), 0);
    send_pkt(make_pkt(BEATS, 8'd8), 0);
    drain();
    check_counters("count");
  endtask

  task automatic test_reset_mid();
    wq_t w = make_pkt(5, 8'd0);
    for (int i = 0; i < 5; i++) send_word(w[i], 1'b0, 0);
    aresetn = 1'b0;
    #1;
    m_jobs = 0; m_short = 0; m_long = 0; m_count = 0;
    checks += 3;
    if (host.tready !== 1'b0) begin errors++; $display("FAIL midrst_host_tready got=%b want=0", host.tready); end
    if (job.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got=%b want=0", job.tvalid); end
    if (job.tdata !== '0) begin errors++; $display("FAIL midrst_desc got=%h want=0", job.tdata); end
    check_counters("midrst");
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    send_pkt(make_pkt(BEATS, 8'd4), 0);
    drain();
    check_counters("after_midrst");
  endtask

  task automatic test_random();
    int len, r;
    rand_rdy = 1;
    fork
      while (rand_rdy) begin
        @(posedge aclk); #1;
        job.tready = ($urandom_range(0, 2) != 0);
      end
    join_none
    for (int p = 0; p < 40; p++) begin
      r = $urandom_range(0, 9);
      if (r < 7) len = BEATS;
      else if (r < 8) len = $urandom_range(1, BEATS-1);
      else len = $urandom_range(BEATS+1, BEATS+8);
      send_pkt(make_pkt(len, 8'($urandom_range(0, 10))), 2);
    end
    drain();
    rand_rdy = 0;
    repeat (2) @(posedge aclk);
    #1;
    job.tready = 1'b1;
    check_counters("random");
  endtask

  initial begin
    host.tvalid = 1'b0;
    host.tdata  = '0;
    host.tlast  = 1'b0;
    job.tready  = 1'b0;
    test_reset();
    test_good();
    test_backpressure();
    test_short();
    test_long();
    test_count();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
